// File: rtl/spi_ram_if.sv
// spi_ram_if: word-level link between the SPI slave and spi_ram.
// The SPI slave (master modport) delivers 10-bit command words on rx_*
// and receives read bytes on tx_*, which it shifts out on MISO.
interface spi_ram_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM behind the SPI slave.
// Decodes the 2-bit command prefix of each rx word, keeps independent
// auto-incrementing write/read pointers and returns read bytes on tx.
// Read path: stage p0 captures the memory word on the RD_DATA edge,
// stage p1 drives tx one edge later.
// Optional macro SPI_RAM_OUT_REG_EN adds output stage p2 (latency 2).
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input logic       clk,
    input logic       rst_n,
    spi_ram_if.slave  bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    cmd_e                 cmd;
    logic [7:0]           payload;
    logic                 wr_cmd;
    logic                 rd_cmd;

    logic [7:0]           rd_data_p0;
    logic                 vld_p0;
    logic [7:0]           tx_data_p1;
    logic                 vld_p1;

    // Addresses at or above MEM_DEPTH are unbacked: writes drop, reads give 0.
    function automatic logic in_range(input logic [ADDR_SIZE-1:0] ptr);
        return (32'(ptr) < MEM_DEPTH);
    endfunction

    // Wraps at MEM_DEPTH-1; out-of-range pointers roll over at 2^ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] ptr);
        if (32'(ptr) == MEM_DEPTH - 1)
            return '0;
        return ptr + ADDR_SIZE'(1);
    endfunction

    assign cmd     = cmd_e'(bus.rx_data[9:8]);
    assign payload = bus.rx_data[7:0];
    assign wr_cmd  = bus.rx_valid && (cmd == CMD_WR_DATA);
    assign rd_cmd  = bus.rx_valid && (cmd == CMD_RD_DATA);

    // Memory write; reset blocks writes but never clears contents.
    always_ff @(posedge clk) begin
        if (rst_n && wr_cmd && in_range(wr_ptr))
            mem[wr_ptr] <= payload;
    end

    // Pointer updates; each command touches only its own pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_ptr <= ADDR_SIZE'(payload);
                CMD_WR_DATA: wr_ptr <= ptr_inc(wr_ptr);
                CMD_RD_ADDR: rd_ptr <= ADDR_SIZE'(payload);
                CMD_RD_DATA: rd_ptr <= ptr_inc(rd_ptr);
                default:     ;
            endcase
        end
    end

    // ---- stage p0: memory read, data qualified by vld_p0 ----
    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= rd_cmd;
    end

    // Read word capture; unqualified data needs no reset.
    always_ff @(posedge clk) begin
        if (rd_cmd)
            rd_data_p0 <= in_range(rd_ptr) ? mem[rd_ptr] : 8'h00;
    end

    // ---- stage p1: tx register, holds last byte while idle ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_p1 <= 8'h00;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                tx_data_p1 <= rd_data_p0;
        end
    end

`ifdef SPI_RAM_OUT_REG_EN
    logic [7:0] tx_data_p2;
    logic       vld_p2;

    // ---- stage p2: extra output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_p2 <= 8'h00;
            vld_p2     <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                tx_data_p2 <= tx_data_p1;
        end
    end

    assign bus.tx_data  = tx_data_p2;
    assign bus.tx_valid = vld_p2;
`else
    assign bus.tx_data  = tx_data_p1;
    assign bus.tx_valid = vld_p1;
`endif

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: drives identical command streams into two spi_ram
// instances (MEM_DEPTH 256 and 200) and scores tx against a model.
module tb_spi_ram;

`ifdef SPI_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = 10'h000;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    exp_t       q[$];
    logic [7:0] mem_m [2][256];
    int         wr_p [2];
    int         rd_p [2];
    int         depth [2] = '{256, 200};
    logic [7:0] last_d [2] = '{8'h00, 8'h00};

    spi_ram_if bus_a ();
    spi_ram_if bus_b ();

    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_valid = rx_valid;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle out of reset, tx must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== e.d0) begin
                    errors++;
                    $display("FAIL read_a cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                             cyc, bus_a.tx_valid, bus_a.tx_data, e.d0);
                end
                checks++;
                if (bus_b.tx_valid !== 1'b1 || bus_b.tx_data !== e.d1) begin
                    errors++;
                    $display("FAIL read_b cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                             cyc, bus_b.tx_valid, bus_b.tx_data, e.d1);
                end
                last_d[0] = e.d0;
                last_d[1] = e.d1;
            end else begin
                checks++;
                if (bus_a.tx_valid !== 1'b0 || bus_b.tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_pulse cyc=%0d: valid a=%b b=%b, required 0",
                             cyc, bus_a.tx_valid, bus_b.tx_valid);
                end
            end
        end
    end

    function automatic int inc(input int i, input int p);
        if (p == depth[i] - 1)
            return 0;
        return (p + 1) & 255;
    endfunction

    // One command word for one cycle; model updated in issue order.
    task automatic send(input logic [1:0] c, input logic [7:0] b);
        logic [7:0] rv [2];
        rx_valid = 1'b1;
        rx_data  = {c, b};
        for (int i = 0; i < 2; i++) begin
            rv[i] = 8'h00;
            case (c)
                2'b00: wr_p[i] = int'(b);
                2'b01: begin
                    if (wr_p[i] < depth[i])
                        mem_m[i][wr_p[i]] = b;
                    wr_p[i] = inc(i, wr_p[i]);
                end
                2'b10: rd_p[i] = int'(b);
                default: begin
                    rv[i] = (rd_p[i] < depth[i]) ? mem_m[i][rd_p[i]] : 8'h00;
                    rd_p[i] = inc(i, rd_p[i]);
                end
            endcase
        end
        if (c == 2'b11)
            q.push_back('{d0: rv[0], d1: rv[1], due: cyc + 1 + LAT});
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 10'h3FF;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            wr_p[i] = 0;
            rd_p[i] = 0;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus_a.tx_valid !== 1'b0 || bus_a.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: valid=%b data=%h, required 0/00", bus_a.tx_valid, bus_a.tx_data);
        end
        checks++;
        if (bus_b.tx_valid !== 1'b0 || bus_b.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: valid=%b data=%h, required 0/00", bus_b.tx_valid, bus_b.tx_data);
        end
        last_d[0] = 8'h00;
        last_d[1] = 8'h00;
        rx_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_fill();
        send(2'b00, 8'h00);
        for (int a = 0; a < 256; a++)
            send(2'b01, 8'(a) ^ 8'h5C);
    endtask

    task automatic test_basic();
        send(2'b00, 8'h10);
        send(2'b01, 8'hA5);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_burst();
        send(2'b00, 8'hFE);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b01, 8'h33);
        send(2'b10, 8'hFE);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_independence();
        send(2'b00, 8'h20);
        send(2'b10, 8'h40);
        send(2'b01, 8'h5A);
        send(2'b11, 8'h00);
        send(2'b10, 8'h20);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_out_of_range();
        send(2'b00, 8'hC8);
        send(2'b01, 8'h77);
        send(2'b10, 8'hC8);
        send(2'b11, 8'h00);
        send(2'b10, 8'hC7);
        send(2'b11, 8'h00);
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_write_then_read();
        send(2'b00, 8'h33);
        send(2'b10, 8'h34);
        send(2'b01, 8'hE1);
        send(2'b01, 8'hE2);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_idle();
        idle(4);
        checks++;
        if (bus_a.tx_valid !== 1'b0 || bus_a.tx_data !== last_d[0]) begin
            errors++;
            $display("FAIL idle_a: valid=%b data=%h, required 0/%h", bus_a.tx_valid, bus_a.tx_data, last_d[0]);
        end
        checks++;
        if (bus_b.tx_valid !== 1'b0 || bus_b.tx_data !== last_d[1]) begin
            errors++;
            $display("FAIL idle_b: valid=%b data=%h, required 0/%h", bus_b.tx_valid, bus_b.tx_data, last_d[1]);
        end
    endtask

    task automatic test_reset_mid_read();
        send(2'b10, 8'h55);
        send(2'b11, 8'h00);
        test_reset();
        idle(LAT + 2);
        send(2'b11, 8'h00);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++)
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        wait_drain();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_basic();
        test_burst();
        test_independence();
        test_out_of_range();
        test_write_then_read();
        test_idle();
        test_reset_mid_read();
        test_back_to_back();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
